crc_frame_ctrl: RTL and testbench

//   Sequences one combinational CRC_Core (DW data bits per step) over a multi-beat frame.

---
 rtl/crc_frame_if.sv | 30 +++
 rtl/crc_frame_ctrl.sv | 81 ++++++++
 tb/tb_crc_frame_ctrl.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/crc_frame_if.sv
// crc_frame_if: beat input and result handshake bundle for crc_frame_ctrl.
interface crc_frame_if #(
    parameter int DW = 8,
    parameter int CW = 16,
    parameter int LW = 16
);
    logic          In_Vld_i;
    logic          In_Rdy_o;
    logic [DW-1:0] Dat_i;
    logic          Sop_i;
    logic          Eop_i;
    logic          Chk_En_i;
    logic [CW-1:0] Ref_Crc_i;
    logic          Res_Vld_o;
    logic          Res_Rdy_i;
    logic [CW-1:0] Crc_o;
    logic          Err_o;
    logic [LW-1:0] Len_o;
    logic          Abort_o;

    modport master (
        output In_Vld_i, Dat_i, Sop_i, Eop_i, Chk_En_i, Ref_Crc_i, Res_Rdy_i,
        input  In_Rdy_o, Res_Vld_o, Crc_o, Err_o, Len_o, Abort_o
    );

    modport slave (
        input  In_Vld_i, Dat_i, Sop_i, Eop_i, Chk_En_i, Ref_Crc_i, Res_Rdy_i,
        output In_Rdy_o, Res_Vld_o, Crc_o, Err_o, Len_o, Abort_o
    );
endinterface

// File: rtl/crc_frame_ctrl.sv
// crc_frame_ctrl: chains an MSB-first CRC over a multi-beat frame and returns
// the final CRC, beat count and optional check result on a result handshake.
module crc_frame_ctrl #(
    parameter int                DW      = 8,
    parameter int                CW      = 16,
    parameter logic [CW:0]       CP      = 17'h18005,
    parameter logic [CW-1:0]     INIT    = 16'h0000,
    parameter logic [CW-1:0]     XOR_OUT = 16'h0000,
    parameter int                LW      = 16
) (
    input  logic       Clk_i,
    input  logic       Rst_n_i,
    crc_frame_if.slave bus
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t        r_state, w_state_nxt;
    logic [CW-1:0] r_crc, r_crc_o;
    logic [LW-1:0] r_cnt, r_len;
    logic          r_err, r_abort;
    logic          w_acc, w_take, w_fin;
    logic [CW-1:0] w_seed, w_step, w_res;
    logic [LW-1:0] w_cnt_nxt;

    // Bit-serial long division unrolled over one beat; works for any DW/CW ratio.
    function automatic logic [CW-1:0] crc_step(input logic [CW-1:0] s, input logic [DW-1:0] d);
        logic [CW-1:0] c;
        c = s;
        for (int i = DW - 1; i >= 0; i--)
            c = {c[CW-2:0], 1'b0} ^ ({CW{c[CW-1] ^ d[i]}} & CP[CW-1:0]);
        return c;
    endfunction

    assign bus.In_Rdy_o  = (r_state != DONE);
    assign bus.Res_Vld_o = (r_state == DONE);
    assign bus.Crc_o     = r_crc_o;
    assign bus.Err_o     = r_err;
    assign bus.Len_o     = r_len;
    assign bus.Abort_o   = r_abort;

    assign w_acc     = bus.In_Vld_i & bus.In_Rdy_o;
    // In IDLE only a Sop beat starts a frame; anything else is dropped.
    assign w_take    = w_acc & (bus.Sop_i | (r_state == BUSY));
    assign w_fin     = w_take & bus.Eop_i;
    assign w_seed    = bus.Sop_i ? INIT : r_crc;
    assign w_step    = crc_step(w_seed, bus.Dat_i);
    assign w_res     = w_step ^ XOR_OUT;
    assign w_cnt_nxt = bus.Sop_i ? LW'(1) : (&r_cnt ? r_cnt : r_cnt + LW'(1));

    always_comb begin
        w_state_nxt = r_state;
        if (r_state == DONE)
            w_state_nxt = bus.Res_Rdy_i ? IDLE : DONE;
        else if (w_take)
            w_state_nxt = bus.Eop_i ? DONE : BUSY;
    end

    always_ff @(posedge Clk_i or negedge Rst_n_i) begin
        if (!Rst_n_i) begin
            r_state <= IDLE;
            r_crc   <= INIT;
            r_cnt   <= '0;
            r_crc_o <= '0;
            r_err   <= 1'b0;
            r_len   <= '0;
            r_abort <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_abort <= w_take & bus.Sop_i & (r_state == BUSY);
            if (w_take) begin
                r_crc <= w_step;
                r_cnt <= w_cnt_nxt;
            end
            if (w_fin) begin
                r_crc_o <= w_res;
                r_err   <= bus.Chk_En_i & (w_res != bus.Ref_Crc_i);
                r_len   <= w_cnt_nxt;
            end
        end
    end
endmodule

// File: tb/tb_crc_frame_ctrl.sv
// tb_crc_frame_ctrl: directed checks of crc_frame_ctrl with hand-computed CRC-16/0x8005 values.
module tb_crc_frame_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;
    int   ab_cnt = 0;
    int   ab_base;
    logic [15:0] held;

    crc_frame_if #(.DW(8), .CW(16), .LW(16)) bus ();

    crc_frame_ctrl dut (
        .Clk_i   (clk),
        .Rst_n_i (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (bus.Abort_o === 1'b1) ab_cnt <= ab_cnt + 1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic beat(input logic [7:0] d, input logic s, input logic e,
                        input logic c = 1'b0, input logic [15:0] r = 16'h0);
        @(negedge clk);
        bus.In_Vld_i = 1'b1; bus.Dat_i = d; bus.Sop_i = s; bus.Eop_i = e;
        bus.Chk_En_i = c; bus.Ref_Crc_i = r;
    endtask

    task automatic idle();
        @(negedge clk);
        bus.In_Vld_i = 1'b0; bus.Sop_i = 1'b0; bus.Eop_i = 1'b0;
    endtask

    // Sends "123456789"; last beat carries Eop when eop is set; optional idle gap after beat 4.
    task automatic frame(input logic eop, input logic c = 1'b0, input logic [15:0] r = 16'h0,
                         input bit gap = 1'b0);
        for (int i = 0; i < 9; i++) begin
            beat(8'h31 + 8'(i), i == 0, eop && i == 8, c, r);
            if (gap && i == 3) begin
                idle();
                idle();
            end
        end
        idle();
    endtask

    task automatic pop();
        bus.Res_Rdy_i = 1'b1;
        @(negedge clk);
        bus.Res_Rdy_i = 1'b0;
        check("pop_vld", 32'(bus.Res_Vld_o), 32'h0);
        check("pop_rdy", 32'(bus.In_Rdy_o), 32'h1);
    endtask

    initial begin
        bus.In_Vld_i = 0; bus.Dat_i = 0; bus.Sop_i = 0; bus.Eop_i = 0;
        bus.Chk_En_i = 0; bus.Ref_Crc_i = 0; bus.Res_Rdy_i = 0;
        repeat (2) @(negedge clk);
        check("rst_rdy", 32'(bus.In_Rdy_o), 32'h1);
        check("rst_vld", 32'(bus.Res_Vld_o), 32'h0);
        check("rst_crc", 32'(bus.Crc_o), 32'h0);
        check("rst_err", 32'(bus.Err_o), 32'h0);
        check("rst_len", 32'(bus.Len_o), 32'h0);
        check("rst_abort", 32'(bus.Abort_o), 32'h0);
        rst_n = 1'b1;

        frame(1'b1);
        check("t1_vld", 32'(bus.Res_Vld_o), 32'h1);
        check("t1_crc", 32'(bus.Crc_o), 32'hFEE8);
        check("t1_len", 32'(bus.Len_o), 32'd9);
        check("t1_err", 32'(bus.Err_o), 32'h0);
        pop();

        frame(1'b1, 1'b1, 16'hFEE8);
        check("t2_err0", 32'(bus.Err_o), 32'h0);
        pop();
        frame(1'b1, 1'b1, 16'hFEE9, 1'b1);
        check("t2_err1", 32'(bus.Err_o), 32'h1);
        check("t2_gap_crc", 32'(bus.Crc_o), 32'hFEE8);
        check("t2_gap_len", 32'(bus.Len_o), 32'd9);

        beat(8'h00, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus.In_Vld_i = 1'b0;
            check("t3_rdy", 32'(bus.In_Rdy_o), 32'h0);
            check("t3_vld", 32'(bus.Res_Vld_o), 32'h1);
            check("t3_crc", 32'(bus.Crc_o), 32'hFEE8);
            check("t3_len", 32'(bus.Len_o), 32'd9);
        end
        pop();
        check("t3_hold_crc", 32'(bus.Crc_o), 32'hFEE8);

        ab_base = ab_cnt;
        beat(8'hA5, 1'b1, 1'b0);
        beat(8'h12, 1'b0, 1'b0);
        beat(8'h77, 1'b0, 1'b0);
        beat(8'hC3, 1'b0, 1'b0);
        frame(1'b1);
        check("t4_abort", 32'(ab_cnt - ab_base), 32'd1);
        check("t4_crc", 32'(bus.Crc_o), 32'hFEE8);
        check("t4_len", 32'(bus.Len_o), 32'd9);
        pop();

        beat(8'hFF, 1'b0, 1'b1);
        idle();
        check("t5_drop_vld", 32'(bus.Res_Vld_o), 32'h0);
        frame(1'b1);
        check("t5_crc", 32'(bus.Crc_o), 32'hFEE8);
        check("t5_len", 32'(bus.Len_o), 32'd9);
        pop();
        beat(8'h00, 1'b1, 1'b1);
        idle();
        check("t5_single_vld", 32'(bus.Res_Vld_o), 32'h1);
        check("t5_single_crc", 32'(bus.Crc_o), 32'h0000);
        check("t5_single_len", 32'(bus.Len_o), 32'd1);
        pop();

        for (int i = 0; i < 5; i++) beat(8'h31 + 8'(i), i == 0, 1'b0);
        idle();
        rst_n = 1'b0;
        #1;
        check("t6_mid_len", 32'(bus.Len_o), 32'h0);
        check("t6_mid_rdy", 32'(bus.In_Rdy_o), 32'h1);
        check("t6_mid_vld", 32'(bus.Res_Vld_o), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        frame(1'b1);
        check("t6_crc", 32'(bus.Crc_o), 32'hFEE8);
        held = bus.Crc_o;
        rst_n = 1'b0;
        #1;
        check("t6_done_vld", 32'(bus.Res_Vld_o), 32'h0);
        check("t6_done_crc", 32'(bus.Crc_o), 32'h0);
        check("t6_done_len", 32'(bus.Len_o), 32'h0);
        check("t6_done_rdy", 32'(bus.In_Rdy_o), 32'h1);
        @(negedge clk);
        rst_n = 1'b1;
        frame(1'b1);
        check("t6_again_crc", 32'(bus.Crc_o), 32'(held));
        check("t6_again_len", 32'(bus.Len_o), 32'd9);
        pop();

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
